// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer feeding instruction memory.
// Chooses halt/stall/jr/jump/branch/increment by priority and faults on out-of-range targets.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_RUN    | normal fetch, pc advances to the selected next address
// S_HALTED | halt decoded, pc frozen until resume
// S_FAULT  | next address fell outside memory, pc frozen until reset
module pc_fetch_ctrl #(
  parameter int unsigned MEM_SIZE   = 500,
  parameter logic [31:0] START_ADDR = 32'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        branch,
  input  logic [15:0] branch_offset,
  input  logic        stall,
  input  logic        halt,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus1,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_FAULT  = 2'd2
  } state_t;

  localparam logic [31:0] LIMIT = 32'(MEM_SIZE);

  state_t      state;
  logic [31:0] cand;
  logic        cand_ok;
  logic        plus1_ok;

  assign pc_plus1 = pc + 32'd1;

  always_comb begin
    cand = pc_plus1;
    if (jr)
      cand = jr_target;
    else if (jump)
      cand = {6'b0, jump_target};
    else if (branch)
      cand = pc_plus1 + {{16{branch_offset[15]}}, branch_offset};
  end

  // A negative branch below zero wraps to a huge value and is caught here too.
  assign cand_ok  = (cand < LIMIT);
  assign plus1_ok = (pc_plus1 < LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc     <= START_ADDR;
      state  <= S_RUN;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (halt) begin
            state  <= S_HALTED;
            halted <= 1'b1;
          end else if (!stall) begin
            if (cand_ok) begin
              pc <= cand;
            end else begin
              state <= S_FAULT;
              fault <= 1'b1;
            end
          end
        end
        S_HALTED: begin
          if (resume) begin
            halted <= 1'b0;
            if (plus1_ok) begin
              pc    <= pc_plus1;
              state <= S_RUN;
            end else begin
              state <= S_FAULT;
              fault <= 1'b1;
            end
          end
        end
        S_FAULT: begin
          fault <= 1'b1;
        end
        default: begin
          state  <= S_FAULT;
          halted <= 1'b0;
          fault  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a vector table for the main scenario
// plus hand-written sequences for async reset and the range boundaries.
module tb_pc_fetch_ctrl;

  typedef struct {
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
    logic        branch;
    logic [15:0] branch_offset;
    logic        stall;
    logic        halt;
    logic        resume;
    logic [31:0] exp_pc;
    logic        exp_halted;
    logic        exp_fault;
  } vec_t;

  logic        clock;
  logic        reset_n;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        branch;
  logic [15:0] branch_offset;
  logic        stall;
  logic        halt;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] pc_plus1;
  logic        halted;
  logic        fault;

  int checks = 0;
  int errors = 0;

  pc_fetch_ctrl #(.MEM_SIZE(500), .START_ADDR(32'd0)) dut (
    .clock(clock), .reset_n(reset_n),
    .jump(jump), .jump_target(jump_target),
    .jr(jr), .jr_target(jr_target),
    .branch(branch), .branch_offset(branch_offset),
    .stall(stall), .halt(halt), .resume(resume),
    .pc(pc), .pc_plus1(pc_plus1), .halted(halted), .fault(fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(logic j, logic [25:0] jt, logic r, logic [31:0] rt,
                              logic b, logic [15:0] off, logic s, logic h, logic res,
                              logic [31:0] epc, logic eh, logic ef);
    vec_t v;
    v.jump = j; v.jump_target = jt; v.jr = r; v.jr_target = rt;
    v.branch = b; v.branch_offset = off; v.stall = s; v.halt = h; v.resume = res;
    v.exp_pc = epc; v.exp_halted = eh; v.exp_fault = ef;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_all(string name, logic [31:0] epc, logic eh, logic ef);
    chk({name, ".pc"}, pc, epc);
    chk({name, ".pc_plus1"}, pc_plus1, epc + 32'd1);
    chk({name, ".halted"}, {31'b0, halted}, {31'b0, eh});
    chk({name, ".fault"}, {31'b0, fault}, {31'b0, ef});
  endtask

  task automatic clear_inputs();
    jump = 0; jump_target = '0; jr = 0; jr_target = '0;
    branch = 0; branch_offset = '0; stall = 0; halt = 0; resume = 0;
  endtask

  // Called at a negedge: drive, clock once, check just after the edge, return at next negedge.
  task automatic step(string name, vec_t v);
    jump = v.jump; jump_target = v.jump_target; jr = v.jr; jr_target = v.jr_target;
    branch = v.branch; branch_offset = v.branch_offset;
    stall = v.stall; halt = v.halt; resume = v.resume;
    @(posedge clock);
    #1;
    chk_all(name, v.exp_pc, v.exp_halted, v.exp_fault);
    @(negedge clock);
  endtask

  task automatic async_reset(string name);
    #2;
    reset_n = 0;
    #1;
    chk_all(name, 32'd0, 1'b0, 1'b0);
    clear_inputs();
    @(negedge clock);
    reset_n = 1;
  endtask

  localparam int NVEC = 31;
  vec_t tbl [NVEC];

  initial begin
    //              j  jt  r  rt    b  off       s  h  res  pc  h  f
    tbl[0]  = mk(0, 0,  0, 0,    0, 16'd0,    0, 0, 0,   1, 0, 0);
    tbl[1]  = mk(0, 0,  0, 0,    0, 16'd0,    0, 0, 0,   2, 0, 0);
    tbl[2]  = mk(0, 0,  0, 0,    0, 16'd0,    0, 0, 0,   3, 0, 0);
    tbl[3]  = mk(1, 13, 0, 0,    0, 16'd0,    0, 0, 0,  13, 0, 0);
    tbl[4]  = mk(0, 0,  1, 24,   0, 16'd0,    0, 0, 0,  24, 0, 0);
    tbl[5]  = mk(1, 9,  1, 4,    0, 16'd0,    0, 0, 0,   4, 0, 0);
    tbl[6]  = mk(1, 10, 0, 0,    0, 16'd0,    0, 0, 0,  10, 0, 0);
    tbl[7]  = mk(0, 0,  0, 0,    1, 16'hFFFD, 0, 0, 0,   8, 0, 0);
    tbl[8]  = mk(0, 0,  0, 0,    1, 16'd5,    0, 0, 0,  14, 0, 0);
    tbl[9]  = mk(0, 0,  0, 0,    1, 16'd5,    1, 0, 0,  14, 0, 0);
    tbl[10] = mk(1, 7,  0, 0,    0, 16'd0,    0, 0, 0,   7, 0, 0);
    tbl[11] = mk(0, 0,  0, 0,    0, 16'd0,    1, 0, 0,   7, 0, 0);
    tbl[12] = mk(0, 0,  0, 0,    0, 16'd0,    1, 0, 0,   7, 0, 0);
    tbl[13] = mk(0, 0,  0, 0,    0, 16'd0,    1, 0, 0,   7, 0, 0);
    tbl[14] = mk(0, 0,  0, 0,    0, 16'd0,    1, 1, 0,   7, 1, 0);
    tbl[15] = mk(1, 30, 0, 0,    0, 16'd0,    0, 0, 0,   7, 1, 0);
    tbl[16] = mk(0, 0,  0, 0,    0, 16'd0,    0, 0, 1,   8, 0, 0);
    tbl[17] = mk(0, 0,  1, 2,    1, 16'd5,    0, 0, 0,   2, 0, 0);
    tbl[18] = mk(1, 3,  0, 0,    0, 16'd0,    0, 0, 0,   3, 0, 0);
    tbl[19] = mk(0, 0,  0, 0,    0, 16'd0,    0, 1, 0,   3, 1, 0);
    tbl[20] = mk(1, 40, 0, 0,    0, 16'd0,    0, 0, 0,   3, 1, 0);
    tbl[21] = mk(1, 40, 0, 0,    0, 16'd0,    0, 0, 0,   3, 1, 0);
    tbl[22] = mk(1, 40, 0, 0,    0, 16'd0,    0, 0, 0,   3, 1, 0);
    tbl[23] = mk(1, 40, 0, 0,    0, 16'd0,    0, 0, 0,   3, 1, 0);
    tbl[24] = mk(1, 40, 0, 0,    0, 16'd0,    0, 0, 0,   3, 1, 0);
    tbl[25] = mk(0, 0,  0, 0,    0, 16'd0,    0, 0, 1,   4, 0, 0);
    tbl[26] = mk(1, 20, 0, 0,    0, 16'd0,    0, 0, 0,  20, 0, 0);
    tbl[27] = mk(0, 0,  1, 500,  0, 16'd0,    0, 0, 0,  20, 0, 1);
    tbl[28] = mk(1, 5,  0, 0,    0, 16'd0,    0, 0, 0,  20, 0, 1);
    tbl[29] = mk(0, 0,  0, 0,    0, 16'd0,    0, 0, 1,  20, 0, 1);
    tbl[30] = mk(0, 0,  0, 0,    0, 16'd0,    0, 1, 0,  20, 0, 1);

    clear_inputs();
    reset_n = 0;
    repeat (2) @(posedge clock);
    #1;
    chk_all("reset", 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1;

    for (int i = 0; i < NVEC; i++)
      step($sformatf("vec%0d", i), tbl[i]);

    // Leave FAULT via async reset asserted mid-cycle.
    async_reset("rst_from_fault");
    step("after_rst0", mk(0, 0, 0, 0, 0, 16'd0, 0, 0, 0, 1, 0, 0));

    // Async reset while stalled.
    step("pre_stall", mk(1, 5, 0, 0, 0, 16'd0, 0, 0, 0, 5, 0, 0));
    step("stall5", mk(0, 0, 0, 0, 0, 16'd0, 1, 0, 0, 5, 0, 0));
    stall = 1;
    async_reset("rst_mid_stall");

    // Async reset while halted.
    step("pre_halt", mk(1, 9, 0, 0, 0, 16'd0, 0, 0, 0, 9, 0, 0));
    step("halt9", mk(0, 0, 0, 0, 0, 16'd0, 0, 1, 0, 9, 1, 0));
    async_reset("rst_mid_halt");

    // Sequential run off the top of memory.
    step("j498", mk(1, 498, 0, 0, 0, 16'd0, 0, 0, 0, 498, 0, 0));
    step("seq499", mk(0, 0, 0, 0, 0, 16'd0, 0, 0, 0, 499, 0, 0));
    step("seq_top_fault", mk(0, 0, 0, 0, 0, 16'd0, 0, 0, 0, 499, 0, 1));
    async_reset("rst_after_top");

    // Resume at the last word must fault, not wrap.
    step("jr499", mk(0, 0, 1, 499, 0, 16'd0, 0, 0, 0, 499, 0, 0));
    step("halt499", mk(0, 0, 0, 0, 0, 16'd0, 0, 1, 0, 499, 1, 0));
    step("resume_top_fault", mk(0, 0, 0, 0, 0, 16'd0, 0, 0, 1, 499, 0, 1));
    async_reset("rst_after_resume");

    // Backward branch below zero wraps and faults.
    step("seq1", mk(0, 0, 0, 0, 0, 16'd0, 0, 0, 0, 1, 0, 0));
    step("branch_neg_fault", mk(0, 0, 0, 0, 1, 16'hFFFB, 0, 0, 0, 1, 0, 1));
    async_reset("rst_after_branch");

    // Branch landing exactly at 0, then huge jr target.
    step("seq1b", mk(0, 0, 0, 0, 0, 16'd0, 0, 0, 0, 1, 0, 0));
    step("branch_to0", mk(0, 0, 0, 0, 1, 16'hFFFE, 0, 0, 0, 0, 0, 0));
    step("jr_huge_fault", mk(0, 0, 1, 32'h8000_0000, 0, 16'd0, 0, 0, 0, 0, 0, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch sequencer for the single-cycle processor; directly upstream of instruction memory.
- Its registered `pc` output drives the instruction memory address input (`endInstr`). The memory samples that address on the next rising clock edge.
- Selects the next PC from sequential increment, absolute jump, register jump or relative branch.
- Supports stall, halt/resume and an out-of-range fault.

Parameters:
- MEM_SIZE, 500: number of instruction words. Legal PC range is 0..MEM_SIZE-1.
- START_ADDR, 0: PC value loaded at reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- jump  in  1  absolute jump request (jmp/jal).
- jump_target  in  26  absolute word address for jump; zero-extended.
- jr  in  1  register jump request.
- jr_target  in  32  word address from register file.
- branch  in  1  conditional branch request; condition already evaluated as true.
- branch_offset  in  16  signed word offset, relative to pc+1.
- stall  in  1  hold PC (e.g., waiting on input device).
- halt  in  1  halt instruction decoded.
- resume  in  1  operator continue pulse; leaves HALTED.
- pc  out  32  current fetch address, to instruction memory.
- pc_plus1  out  32  pc+1, combinational; return address for jal.
- halted  out  1  high while in HALTED.
- fault  out  1  high while in FAULT.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - pc=START_ADDR, state=RUN, halted=0, fault=0.
  - Takes effect immediately, including mid-stall or mid-halt.
- pc updates only on rising clock edges while reset_n=1.
- States: RUN, HALTED, FAULT.
- RUN, next-PC priority (highest first):
  1. halt: pc holds; go to HALTED.
  2. stall: pc holds.
  3. jr: next = jr_target.
  4. jump: next = {6'b0, jump_target}.
  5. branch: next = pc + 1 + sign_extend(branch_offset). Computed in 32 bits; wraps modulo 2^32.
  6. Otherwise: next = pc + 1.
  - Simultaneous requests are resolved strictly by this priority. Lower requests are ignored, with no queuing.
- Range check, applied to the candidate next value in cases 3–6:
  - If next >= MEM_SIZE: pc holds its current value, state goes to FAULT, fault=1.
  - Sequential increment at pc=MEM_SIZE-1 therefore faults; it does not wrap to 0.
- HALTED:
  - pc holds and halted=1. All requests except resume are ignored.
  - resume=1: state goes to RUN, pc = pc+1 on that same edge (continues after the halt instruction).
  - If pc+1 >= MEM_SIZE: go to FAULT instead.
- FAULT:
  - pc holds, fault=1. Exit only via reset.
- Latency:
  - A request sampled at edge N appears on pc after edge N.
  - The corresponding instruction appears at the memory output after edge N+1.
- pc_plus1 always equals pc+1 (32-bit), independent of state.
- halted and fault are registered and mutually exclusive.

Test Plan:
- Reset then run: deassert reset_n with no requests. pc goes 0,1,2,3 on successive edges; halted=0, fault=0. Assert reset_n=0 asynchronously mid-cycle at pc=3: pc=0 immediately.
- Jumps: at pc=3, jump=1 with jump_target=13 gives pc=13. Next cycle jr=1 with jr_target=24 gives pc=24. At pc=24, jump=1 and jr=1 with jr_target=4, jump_target=9 together give pc=4 (jr wins).
- Branch: at pc=10, branch_offset=0xFFFD (-3) gives pc=8. At pc=8, offset=5 gives pc=14. At pc=14, branch=1 with stall=1 keeps pc=14.
- Halt/resume: at pc=3, halt=1 gives pc=3 and halted=1. Five cycles with jump=1 leave pc=3. resume=1 gives pc=4 and halted=0.
- Range fault, MEM_SIZE=500: jr_target=500 at pc=20 gives pc=20 and fault=1. Further requests and resume leave pc=20. reset_n=0 gives pc=0, fault=0. Sequential run from pc=499 gives pc=499, fault=1.
- Stall priority: at pc=7, stall=1 for 3 cycles holds pc=7. stall=1 with halt=1 gives HALTED at pc=7. pc_plus1=8 throughout.
